// File: rtl/mem_stage_access_ctrl_if.sv
// ============================================================================
// Module   : mem_stage_access_ctrl_if
// Brief    : req/ack data-memory bus between the MEM-stage controller and memory
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_stage_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int c_LANES = DATA_W / 8;

    logic                mem_req;
    logic                mem_we;
    logic [c_LANES-1:0]  mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
// ============================================================================
// Module   : mem_stage_access_ctrl
// Brief    : MEM-stage load/store controller with req/ack handshake, lane
//            placement, load extension and timeout. Optional macro
//            MEM_ALIGN_CHECK_EN rejects misaligned accesses with bus_err.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_access_ctrl #(
    parameter int REG_W   = 128,
    parameter int OP_LSB  = 26,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [REG_W-1:0]    exmem_reg,
    input  wire logic                in_valid,
    input  wire logic [ADDR_W-1:0]   ex_addr,
    input  wire logic [DATA_W-1:0]   ex_wdata,
    mem_stage_access_ctrl_if.master  mem,
    output logic                     stall,
    output logic [DATA_W-1:0]        load_data,
    output logic                     load_valid,
    output logic                     bus_err
);
    localparam int c_LANES  = DATA_W / 8;
    localparam int c_LANE_W = $clog2(c_LANES);
    localparam int c_CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [5:0]          w_op;
    logic                w_memop;
    logic                w_we;
    logic                w_sext;
    logic [1:0]          w_size;
    logic [c_LANE_W-1:0] w_lomask;
    logic [c_LANES-1:0]  w_bmask;
    logic [c_LANE_W-1:0] w_lane_raw;
    logic [c_LANE_W-1:0] w_lane_eff;
    logic [c_LANES-1:0]  w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_align_err;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_ext;
    logic                w_unused;

    logic [c_LANE_W-1:0] r_lane;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [c_CNT_W-1:0]  r_wait;

    assign w_op     = exmem_reg[OP_LSB+5:OP_LSB];
    assign w_unused = ^exmem_reg;

    // Size code: 0 = byte, 1 = halfword, 2 = word.
    always_comb begin
        w_memop  = 1'b1;
        w_we     = 1'b0;
        w_sext   = 1'b0;
        w_size   = 2'd0;
        case (w_op)
            6'b100011: begin w_size = 2'd2; w_sext = 1'b1; end
            6'b101011: begin w_size = 2'd2; w_we   = 1'b1; end
            6'b100001: begin w_size = 2'd1; w_sext = 1'b1; end
            6'b100101: begin w_size = 2'd1;                end
            6'b101001: begin w_size = 2'd1; w_we   = 1'b1; end
            6'b100000: begin w_size = 2'd0; w_sext = 1'b1; end
            6'b100100: begin w_size = 2'd0;                end
            6'b101000: begin w_size = 2'd0; w_we   = 1'b1; end
            default:   w_memop = 1'b0;
        endcase
    end

    always_comb begin
        w_lomask = '0;
        w_bmask  = c_LANES'(1);
        case (w_size)
            2'd0:    begin w_lomask = '0;             w_bmask = c_LANES'(1);  end
            2'd1:    begin w_lomask = c_LANE_W'(1);   w_bmask = c_LANES'(3);  end
            default: begin w_lomask = c_LANE_W'(3);   w_bmask = c_LANES'(15); end
        endcase
    end

    assign w_lane_raw = ex_addr[c_LANE_W-1:0];
    assign w_lane_eff = w_lane_raw & ~w_lomask;
    assign w_be       = w_bmask << w_lane_eff;
    assign w_wdata    = ex_wdata << {w_lane_eff, 3'b000};
    assign w_addr     = {ex_addr[ADDR_W-1:c_LANE_W], c_LANE_W'(0)};

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [c_LANE_W:0] c_LANES_EXT = (c_LANE_W+1)'(c_LANES);
    logic [c_LANE_W:0] w_nbytes;
    assign w_nbytes    = {1'b0, w_lomask} + (c_LANE_W+1)'(1);
    assign w_align_err = (|(w_lane_raw & w_lomask)) ||
                         (({1'b0, w_lane_raw} + w_nbytes) > c_LANES_EXT);
`else
    assign w_align_err = 1'b0;
`endif

    assign w_timeout = (TIMEOUT != 0) && (r_wait == c_CNT_W'(TIMEOUT - 1));

    // Load extraction uses the lane/size captured at request time.
    assign w_shifted = mem.mem_rdata >> {r_lane, 3'b000};
    always_comb begin
        w_ext = '0;
        case (r_size)
            2'd0:    w_ext = r_sext ? DATA_W'($signed(w_shifted[7:0]))  : DATA_W'(w_shifted[7:0]);
            2'd1:    w_ext = r_sext ? DATA_W'($signed(w_shifted[15:0])) : DATA_W'(w_shifted[15:0]);
            default: w_ext = r_sext ? DATA_W'($signed(w_shifted[31:0])) : DATA_W'(w_shifted[31:0]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // stall is masked by rst so it falls the moment reset asserts.
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && in_valid && w_memop) begin
                    stall       = 1'b1;
                    w_state_nxt = w_align_err ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall = !rst;
                if (mem.mem_ack || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            load_data     <= '0;
            load_valid    <= 1'b0;
            bus_err       <= 1'b0;
            r_lane        <= '0;
            r_size        <= 2'd0;
            r_sext        <= 1'b0;
            r_wait        <= '0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (in_valid && w_memop) begin
                        if (w_align_err) begin
                            bus_err   <= 1'b1;
                            load_data <= '0;
                        end else begin
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= w_we;
                            mem.mem_be    <= w_be;
                            mem.mem_addr  <= w_addr;
                            mem.mem_wdata <= w_we ? w_wdata : '0;
                            r_lane        <= w_lane_eff;
                            r_size        <= w_size;
                            r_sext        <= w_sext;
                        end
                    end
                end
                S_REQ: begin
                    r_wait <= r_wait + c_CNT_W'(1);
                    if (mem.mem_ack || w_timeout) begin
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_be    <= '0;
                        mem.mem_addr  <= '0;
                        mem.mem_wdata <= '0;
                        r_wait        <= '0;
                        // Ack has priority over a coincident timeout.
                        if (mem.mem_ack) begin
                            if (!mem.mem_we) begin
                                load_data  <= w_ext;
                                load_valid <= 1'b1;
                            end
                        end else begin
                            bus_err   <= 1'b1;
                            load_data <= '0;
                        end
                    end
                end
                default: r_wait <= '0;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_access_ctrl
// Brief    : directed self-checking bench for mem_stage_access_ctrl (TIMEOUT=4)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_access_ctrl;
    localparam int REG_W   = 128;
    localparam int OP_LSB  = 26;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [REG_W-1:0]  exmem_reg = '0;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] ex_addr = '0;
    logic [DATA_W-1:0] ex_wdata = '0;
    logic              stall;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;
    int          stall_cyc;
    int          req_cyc;

    always #5 clk = ~clk;

    mem_stage_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    mem_stage_access_ctrl #(
        .REG_W(REG_W), .OP_LSB(OP_LSB), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .exmem_reg(exmem_reg), .in_valid(in_valid),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .mem(mem_if.master),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .bus_err(bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issues one op, answers ack on REQ cycle ack_cyc (0 = never), returns in the cycle stall drops.
    task automatic do_access(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_cyc,
                             input logic [31:0] rdata);
        logic ended;
        ended     = 1'b0;
        stall_cyc = 0;
        req_cyc   = 0;
        cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        @(negedge clk);
        exmem_reg = '0;
        exmem_reg[OP_LSB+5:OP_LSB] = op;
        ex_addr  = addr;
        ex_wdata = wdata;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) in_valid = 1'b0;
            mem_if.mem_ack = 1'b0;
            if (mem_if.mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    cap_be    = mem_if.mem_be;
                    cap_addr  = mem_if.mem_addr;
                    cap_wdata = mem_if.mem_wdata;
                    cap_we    = mem_if.mem_we;
                end
                if (req_cyc == ack_cyc) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = rdata;
                end
            end
            #1;
            if (!stall) begin
                ended = 1'b1;
                break;
            end
            stall_cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ended) check_eq("access_bound", 32'(ended), 32'd1);
    endtask

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_load_data", load_data, 32'd0);
        check_eq("rst_load_valid", 32'(load_valid), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // lw, ack on second REQ cycle
        do_access(OP_LW, 32'h10, 32'h0, 2, 32'h8000_00F0);
        check_eq("lw_stall_cyc", 32'(stall_cyc), 32'd3);
        check_eq("lw_req_cyc", 32'(req_cyc), 32'd2);
        check_eq("lw_be", 32'(cap_be), 32'hF);
        check_eq("lw_addr", cap_addr, 32'h10);
        check_eq("lw_we", 32'(cap_we), 32'd0);
        check_eq("lw_load_valid", 32'(load_valid), 32'd1);
        check_eq("lw_load_data", load_data, 32'h8000_00F0);
        check_eq("lw_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk); #1;
        check_eq("lw_valid_pulse", 32'(load_valid), 32'd0);
        check_eq("lw_data_held", load_data, 32'h8000_00F0);

        do_access(OP_LB, 32'h13, 32'h0, 1, 32'h8A00_0000);
        check_eq("lb_be", 32'(cap_be), 32'h8);
        check_eq("lb_addr", cap_addr, 32'h10);
        check_eq("lb_stall_cyc", 32'(stall_cyc), 32'd2);
        check_eq("lb_load_data", load_data, 32'hFFFF_FF8A);

        do_access(OP_LBU, 32'h13, 32'h0, 1, 32'h8A00_0000);
        check_eq("lbu_load_data", load_data, 32'h0000_008A);
        check_eq("lbu_load_valid", 32'(load_valid), 32'd1);

        do_access(OP_SH, 32'h22, 32'h1234, 1, 32'hFFFF_FFFF);
        check_eq("sh_we", 32'(cap_we), 32'd1);
        check_eq("sh_be", 32'(cap_be), 32'hC);
        check_eq("sh_wdata", cap_wdata, 32'h1234_0000);
        check_eq("sh_addr", cap_addr, 32'h20);
        check_eq("sh_no_load_valid", 32'(load_valid), 32'd0);
        check_eq("sh_data_held", load_data, 32'h0000_008A);

        do_access(OP_LH, 32'h2, 32'h0, 1, 32'hFF7F_0000);
        check_eq("lh_be", 32'(cap_be), 32'hC);
        check_eq("lh_load_data", load_data, 32'hFFFF_FF7F);

        do_access(OP_LHU, 32'h0, 32'h0, 1, 32'h1234_ABCD);
        check_eq("lhu_be", 32'(cap_be), 32'h3);
        check_eq("lhu_load_data", load_data, 32'h0000_ABCD);

        do_access(OP_SW, 32'h8, 32'hDEAD_BEEF, 1, 32'h0);
        check_eq("sw_be", 32'(cap_be), 32'hF);
        check_eq("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        check_eq("sw_addr", cap_addr, 32'h8);

        // no ack: TIMEOUT REQ cycles then bus_err
        do_access(OP_LW, 32'h40, 32'h0, 0, 32'h0);
        check_eq("to_req_cyc", 32'(req_cyc), 32'd4);
        check_eq("to_stall_cyc", 32'(stall_cyc), 32'd5);
        check_eq("to_bus_err", 32'(bus_err), 32'd1);
        check_eq("to_load_data", load_data, 32'd0);
        check_eq("to_load_valid", 32'(load_valid), 32'd0);
        @(negedge clk); #1;
        check_eq("to_err_pulse", 32'(bus_err), 32'd0);

        // ack coincides with the timeout cycle
        do_access(OP_LW, 32'h44, 32'h0, 4, 32'h5555_AAAA);
        check_eq("ackto_bus_err", 32'(bus_err), 32'd0);
        check_eq("ackto_load_data", load_data, 32'h5555_AAAA);

        // non-memory op and stray ack in IDLE
        @(negedge clk);
        exmem_reg = '0;
        exmem_reg[OP_LSB+5:OP_LSB] = 6'b000000;
        in_valid = 1'b1;
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("nop_stall", 32'(stall), 32'd0);
        @(negedge clk); #1;
        check_eq("nop_mem_req", 32'(mem_if.mem_req), 32'd0);
        check_eq("stray_ack_valid", 32'(load_valid), 32'd0);
        check_eq("stray_ack_data", load_data, 32'h5555_AAAA);
        in_valid = 1'b0;
        mem_if.mem_ack = 1'b0;

        // asynchronous reset in the middle of REQ
        @(negedge clk);
        exmem_reg = '0;
        exmem_reg[OP_LSB+5:OP_LSB] = OP_LW;
        ex_addr = 32'h50;
        in_valid = 1'b1;
        @(negedge clk); #1;
        check_eq("mid_req_up", 32'(mem_if.mem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_req_drop", 32'(mem_if.mem_req), 32'd0);
        check_eq("rst_stall_drop", 32'(stall), 32'd0);
        check_eq("rst_data_clr", load_data, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_access(OP_LW, 32'h50, 32'h0, 1, 32'h0BAD_F00D);
        check_eq("post_rst_stall", 32'(stall_cyc), 32'd2);
        check_eq("post_rst_data", load_data, 32'h0BAD_F00D);

        // misaligned word access
        do_access(OP_LW, 32'h2, 32'h0, 1, 32'h1357_2468);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("mis_req_cyc", 32'(req_cyc), 32'd0);
        check_eq("mis_bus_err", 32'(bus_err), 32'd1);
        check_eq("mis_load_data", load_data, 32'd0);
        check_eq("mis_stall_cyc", 32'(stall_cyc), 32'd1);
`else
        check_eq("mis_req_cyc", 32'(req_cyc), 32'd1);
        check_eq("mis_addr", cap_addr, 32'h0);
        check_eq("mis_be", 32'(cap_be), 32'hF);
        check_eq("mis_bus_err", 32'(bus_err), 32'd0);
        check_eq("mis_load_data", load_data, 32'h1357_2468);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
